// File: rtl/tick_pkg.sv
// Shared constants and types for the tick_bank periodic tick generator.
package tick_pkg;

    localparam int unsigned CH_IDX_W     = 4;
    localparam int unsigned DIV_60HZ     = 1_666_667;
    localparam int unsigned DIV_1HZ      = 100_000_000;
    localparam int unsigned TICK_DEF_DIV = DIV_60HZ;

    typedef enum logic [2:0] {
        ACT_SYNC,
        ACT_LOAD,
        ACT_STOP,
        ACT_HOLD,
        ACT_WRAP,
        ACT_COUNT
    } chan_act_e;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: divisor register, period counter, tick pulse and square output.
module tick_chan
    import tick_pkg::*;
#(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned DEF_DIV = TICK_DEF_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    chan_act_e        act_c;

    // Priority: realign, then divisor load, then stopped, then frozen, then count.
    always_comb begin
        act_c = ACT_HOLD;
        if (sync) begin
            act_c = ACT_SYNC;
        end else if (wr_en) begin
            act_c = ACT_LOAD;
        end else if (div == '0) begin
            act_c = ACT_STOP;
        end else if (!en) begin
            act_c = ACT_HOLD;
        end else if (cnt == div - CNT_W'(1)) begin
            act_c = ACT_WRAP;
        end else begin
            act_c = ACT_COUNT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            div  <= RST_DIV;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else begin
            tick <= 1'b0;
            // A realign does not block the divisor update of a simultaneous write.
            if (wr_en) begin
                div <= wr_div;
            end
            case (act_c)
                ACT_SYNC: begin
                    cnt <= '0;
                    sq  <= 1'b0;
                end
                ACT_LOAD, ACT_STOP: begin
                    cnt <= '0;
                end
                ACT_WRAP: begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    sq   <= ~sq;
                end
                ACT_COUNT: begin
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/tick_bank.sv
// Bank of NUM_CH programmable tick generators with a shared divisor write port.
// Optional global realign input enabled by defining TICK_BANK_SYNC_EN.
module tick_bank
    import tick_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned DEF_DIV = TICK_DEF_DIV
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    input  logic [CH_IDX_W-1:0] wr_ch,
    input  logic [CNT_W-1:0]    wr_div,
    output logic                wr_ack,
    output logic                wr_err,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                sync,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   sq
);

    localparam int unsigned SEL_W = CH_IDX_W + 1;

    logic              wr_ok_c;
    logic              sync_c;
    logic [NUM_CH-1:0] wr_sel_c;

`ifdef TICK_BANK_SYNC_EN
    assign sync_c = sync;
`else
    logic unused_sync;
    assign unused_sync = sync;
    assign sync_c      = 1'b0;
`endif

    // Widened compare so NUM_CH = 16 does not wrap.
    assign wr_ok_c = wr_valid && ({1'b0, wr_ch} < SEL_W'(NUM_CH));

    always_comb begin
        wr_sel_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            wr_sel_c[i] = wr_ok_c && (wr_ch == CH_IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_ok_c;
            wr_err <= wr_valid && !wr_ok_c;
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        tick_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .en     (ch_en[g]),
            .sync   (sync_c),
            .wr_en  (wr_sel_c[g]),
            .wr_div (wr_div),
            .tick   (tick[g]),
            .sq     (sq[g])
        );
    end

endmodule

// File: tb/tb_tick_bank.sv
// Directed scoreboard bench for tick_bank with DEF_DIV = 5 and four channels.
module tb_tick_bank;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 24;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sq;
        logic           ack;
        logic           err;
    } exp_t;

    logic           clk;
    logic           reset;
    logic           wr_valid;
    logic [3:0]     wr_ch;
    logic [CW-1:0]  wr_div;
    logic           wr_ack;
    logic           wr_err;
    logic [NCH-1:0] ch_en;
    logic           sync;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;

    exp_t           q[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    int             rec      = 0;
    int             k        = 0;
    int             nt[NCH];
    int             per[NCH];
    logic [NCH-1:0] exp_sq;

    tick_bank #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DEF_DIV (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .wr_ack   (wr_ack),
        .wr_err   (wr_err),
        .ch_en    (ch_en),
        .sync     (sync),
        .tick     (tick),
        .sq       (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s rec=%0d: got 0x%0h, expected 0x%0h", name, rec, got, expv);
        end
    endtask

    // Monitor: one expected record per clock edge, compared away from the edge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("tick_sq", 32'({tick, sq}), 32'({e.tick, e.sq}));
            chk("ack_err", 32'({wr_ack, wr_err}), 32'({e.ack, e.err}));
            rec++;
        end
    end

    // Expected outputs after the next edge, while reset is held.
    task automatic rst_step();
        q.push_back('{tick: '0, sq: '0, ack: 1'b0, err: 1'b0});
        @(posedge clk);
        #1;
    endtask

    // Expected outputs after the next edge; channels tick on their scheduled edge.
    task automatic step(input logic a, input logic e);
        logic [NCH-1:0] m;
        k++;
        m = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (nt[i] == k) begin
                m[i]   = 1'b1;
                nt[i] += per[i];
            end
        end
        exp_sq ^= m;
        q.push_back('{tick: m, sq: exp_sq, ack: a, err: e});
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Accepted write: counter restarts, first tick div edges after the write edge.
    task automatic wr_step(input logic [3:0] ch, input int unsigned d, input bit ok);
        wr_valid = 1'b1;
        wr_ch    = ch;
        wr_div   = CW'(d);
        if (ok) begin
            per[ch] = int'(d);
            nt[ch]  = (d == 0) ? -1 : k + 1 + int'(d);
        end
        step(ok, !ok);
        wr_valid = 1'b0;
    endtask

    task automatic release_rst();
        reset  = 1'b0;
        ch_en  = '1;
        k      = 0;
        exp_sq = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            nt[i]  = 5;
            per[i] = 5;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        ch_en    = '0;
        sync     = 1'b0;
        wr_valid = 1'b1;
        wr_ch    = 4'd0;
        wr_div   = CW'(2);
        exp_sq   = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            nt[i]  = -1;
            per[i] = 0;
        end
        // Write during reset must be discarded; ch0 keeps the reset divisor.
        rst_step();
        rst_step();
        rst_step();
        wr_valid = 1'b0;
        release_rst();

        // All channels in phase, tick every 5, sq period 10.
        steps(24);

        // Write ch1 div=3 while its count is 4: tick suppressed, next tick 3 later.
        wr_step(4'd1, 3, 1'b1);
        steps(6);

        // Out-of-range channels back to back: error pulses, no state change.
        wr_step(4'd7, 9, 1'b0);
        wr_step(4'd15, 9, 1'b0);
        steps(8);

        // ch2 stopped with div=0, then div=1 ticks every cycle.
        wr_step(4'd2, 0, 1'b1);
        steps(6);
        wr_step(4'd2, 1, 1'b1);
        steps(6);
        wr_step(4'd2, 5, 1'b1);
        steps(3);

        // Largest legal divisor is accepted without spurious ticks.
        wr_step(4'd3, 32'h00FF_FFFF, 1'b1);
        steps(2);

        // Freeze ch0 at count 2 for 7 cycles; its tick slips by exactly 7.
        for (int n = 0; n < 10 && (nt[0] - k) != 3; n++) step(1'b0, 1'b0);
        ch_en[0] = 1'b0;
        nt[0]   += 7;
        steps(7);
        ch_en[0] = 1'b1;
        steps(10);

`ifdef TICK_BANK_SYNC_EN
        // Realign with a simultaneous write: all counters and sq cleared, divisor kept.
        sync    = 1'b1;
        per[0]  = 2;
        for (int i = 0; i < int'(NCH); i++) nt[i] = k + 1 + per[i];
        exp_sq  = '0;
        wr_valid = 1'b1;
        wr_ch    = 4'd0;
        wr_div   = CW'(2);
        step(1'b1, 1'b0);
        wr_valid = 1'b0;
        sync     = 1'b0;
`else
        // Without the realign feature, sync is ignored and the write acts normally.
        sync = 1'b1;
        wr_step(4'd0, 2, 1'b1);
        sync = 1'b0;
`endif
        steps(11);

        // Asynchronous reset mid-period clears outputs before any clock edge.
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset", 32'({tick, sq, wr_ack, wr_err}), 32'd0);
        rst_step();
        rst_step();
        release_rst();
        steps(12);

        for (int n = 0; n < 5 && q.size() != 0; n++) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d records left, expected 0", q.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
